// File: rtl/l1a_readout_sched.sv
// Admits accepted L1As into a pending-event queue with raw/best memory reservation and
// hands events one at a time to the DAQ frame formatter. Optional watchdog: DAQ_TIMEOUT_EN.
module l1a_readout_sched #(
    parameter int unsigned QDEPTH_LOG2 = 3,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                   i_clk,
    input  logic                   i_hard_rst,
    input  logic                   i_l1a_in,
    input  logic [11:0]            i_l1a_bxn,
    input  logic [ADDR_W-1:0]      i_raw_adw,
    input  logic [ADDR_W-1:0]      i_best_adw,
    input  logic [4:0]             i_fifo_tbins,
    input  logic [3:0]             i_l1a_window,
    output logic                   o_ro_start,
    output logic [ADDR_W-1:0]      o_ro_raw_adb,
    output logic [ADDR_W-1:0]      o_ro_best_adb,
    output logic [11:0]            o_ro_bxn,
    output logic [11:0]            o_ro_l1a_num,
    input  logic                   i_ro_done,
    output logic                   o_busy,
    output logic [QDEPTH_LOG2:0]   o_queue_count,
    output logic                   o_queue_full,
    output logic                   o_l1a_dropped,
    output logic [7:0]             o_drop_cnt,
    output logic                   o_ro_error
);
    localparam int unsigned QDEPTH = 2 ** QDEPTH_LOG2;
    localparam int unsigned SUM_W  = ADDR_W + 2;
    localparam int unsigned RES_W  = ADDR_W + 1;
    localparam logic [SUM_W-1:0] MEM_CAP = SUM_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitDone,
        StRelease
    } state_e;

    state_e r_state, w_state_next;

    logic [11:0]       r_q_bxn    [QDEPTH];
    logic [11:0]       r_q_num    [QDEPTH];
    logic [ADDR_W-1:0] r_q_raw    [QDEPTH];
    logic [ADDR_W-1:0] r_q_best   [QDEPTH];
    logic [4:0]        r_q_tbins  [QDEPTH];
    logic [3:0]        r_q_window [QDEPTH];

    logic [QDEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [QDEPTH_LOG2:0]   r_count, w_count_next;
    logic [RES_W-1:0]       r_raw_res, r_best_res;
    logic [11:0]            r_l1a_num;
    logic                   r_l1a_dropped;
    logic [7:0]             r_drop_cnt;
    logic [ADDR_W-1:0]      r_ro_raw_adb, r_ro_best_adb;
    logic [11:0]            r_ro_bxn, r_ro_l1a_num;

    logic             w_full, w_admit, w_pop, w_wdog_expire;
    logic [SUM_W-1:0] w_raw_sum, w_best_sum;
    logic [RES_W-1:0] w_raw_add, w_raw_sub, w_best_add, w_best_sub;

    // Admission uses the pre-release reservation, so a same-cycle release never helps.
    assign w_full     = (r_count == (QDEPTH_LOG2 + 1)'(QDEPTH));
    assign w_raw_sum  = SUM_W'(r_raw_res) + SUM_W'(i_fifo_tbins);
    assign w_best_sum = SUM_W'(r_best_res) + SUM_W'(i_l1a_window);
    assign w_admit    = i_l1a_in && !w_full && (w_raw_sum <= MEM_CAP) && (w_best_sum <= MEM_CAP);
    assign w_pop      = (r_state == StRelease);

    assign w_raw_add  = w_admit ? RES_W'(i_fifo_tbins) : '0;
    assign w_best_add = w_admit ? RES_W'(i_l1a_window) : '0;
    assign w_raw_sub  = w_pop ? RES_W'(r_q_tbins[r_rd_ptr]) : '0;
    assign w_best_sub = w_pop ? RES_W'(r_q_window[r_rd_ptr]) : '0;

    always_comb begin
        w_count_next = r_count;
        if (w_admit && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_admit && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_admit) begin
            r_q_bxn[r_wr_ptr]    <= i_l1a_bxn;
            r_q_num[r_wr_ptr]    <= r_l1a_num;
            r_q_raw[r_wr_ptr]    <= i_raw_adw;
            r_q_best[r_wr_ptr]   <= i_best_adw;
            r_q_tbins[r_wr_ptr]  <= i_fifo_tbins;
            r_q_window[r_wr_ptr] <= i_l1a_window;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_hard_rst) begin
            r_state       <= StIdle;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_raw_res     <= '0;
            r_best_res    <= '0;
            r_l1a_num     <= '0;
            r_l1a_dropped <= 1'b0;
            r_drop_cnt    <= '0;
            r_ro_raw_adb  <= '0;
            r_ro_best_adb <= '0;
            r_ro_bxn      <= '0;
            r_ro_l1a_num  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_raw_res  <= r_raw_res + w_raw_add - w_raw_sub;
            r_best_res <= r_best_res + w_best_add - w_best_sub;
            if (w_admit) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Every strobe consumes a number, so dropped L1As leave gaps.
            if (i_l1a_in) begin
                r_l1a_num <= r_l1a_num + 1'b1;
            end
            r_l1a_dropped <= i_l1a_in && !w_admit;
            if (i_l1a_in && !w_admit && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (r_state == StLoad) begin
                r_ro_raw_adb  <= r_q_raw[r_rd_ptr];
                r_ro_best_adb <= r_q_best[r_rd_ptr];
                r_ro_bxn      <= r_q_bxn[r_rd_ptr];
                r_ro_l1a_num  <= r_q_num[r_rd_ptr];
            end
        end
    end

`ifdef DAQ_TIMEOUT_EN
    logic [9:0] r_wdog;
    logic       r_ro_error;

    assign w_wdog_expire = (r_state == StWaitDone) && !i_ro_done &&
                           (r_wdog == 10'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_hard_rst) begin
            r_wdog     <= '0;
            r_ro_error <= 1'b0;
        end else begin
            if (r_state == StStart) begin
                r_wdog <= '0;
            end else if (r_state == StWaitDone) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_wdog_expire) begin
                r_ro_error <= 1'b1;
            end
        end
    end

    assign o_ro_error = r_ro_error;
`else
    assign w_wdog_expire = 1'b0;
    assign o_ro_error    = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (r_count != '0) w_state_next = StLoad;
            StLoad:     w_state_next = StStart;
            StStart:    w_state_next = StWaitDone;
            StWaitDone: if (i_ro_done || w_wdog_expire) w_state_next = StRelease;
            StRelease:  w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    assign o_ro_start    = (r_state == StStart);
    assign o_busy        = (r_state != StIdle);
    assign o_ro_raw_adb  = r_ro_raw_adb;
    assign o_ro_best_adb = r_ro_best_adb;
    assign o_ro_bxn      = r_ro_bxn;
    assign o_ro_l1a_num  = r_ro_l1a_num;
    assign o_queue_count = r_count;
    assign o_queue_full  = w_full;
    assign o_l1a_dropped = r_l1a_dropped;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_l1a_readout_sched.sv
// Directed bench for l1a_readout_sched: default instance plus a 32-word-memory instance for
// reservation boundaries. Watchdog case built only with DAQ_TIMEOUT_EN.
module tb_l1a_readout_sched;
    logic        clk = 1'b0;
    logic        hard_rst, l1a_in, ro_done;
    logic [11:0] l1a_bxn;
    logic [7:0]  raw_adw, best_adw;
    logic [4:0]  fifo_tbins;
    logic [3:0]  l1a_window;

    logic        ro_start, busy, queue_full, l1a_dropped, ro_error;
    logic [7:0]  ro_raw_adb, ro_best_adb, drop_cnt;
    logic [11:0] ro_bxn, ro_l1a_num;
    logic [3:0]  queue_count;

    logic [4:0]  s_raw_adw, s_best_adw, s_ro_raw_adb, s_ro_best_adb;
    logic        s_ro_start, s_busy, s_queue_full, s_l1a_dropped, s_ro_error;
    logic [11:0] s_ro_bxn, s_ro_l1a_num;
    logic [3:0]  s_queue_count;
    logic [7:0]  s_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    assign s_raw_adw  = raw_adw[4:0];
    assign s_best_adw = best_adw[4:0];

    always #5 clk = ~clk;

    l1a_readout_sched u_dut (
        .i_clk(clk), .i_hard_rst(hard_rst), .i_l1a_in(l1a_in), .i_l1a_bxn(l1a_bxn),
        .i_raw_adw(raw_adw), .i_best_adw(best_adw), .i_fifo_tbins(fifo_tbins),
        .i_l1a_window(l1a_window), .o_ro_start(ro_start), .o_ro_raw_adb(ro_raw_adb),
        .o_ro_best_adb(ro_best_adb), .o_ro_bxn(ro_bxn), .o_ro_l1a_num(ro_l1a_num),
        .i_ro_done(ro_done), .o_busy(busy), .o_queue_count(queue_count),
        .o_queue_full(queue_full), .o_l1a_dropped(l1a_dropped), .o_drop_cnt(drop_cnt),
        .o_ro_error(ro_error)
    );

    l1a_readout_sched #(.QDEPTH_LOG2(3), .ADDR_W(5), .TIMEOUT(1023)) u_dut_small (
        .i_clk(clk), .i_hard_rst(hard_rst), .i_l1a_in(l1a_in), .i_l1a_bxn(l1a_bxn),
        .i_raw_adw(s_raw_adw), .i_best_adw(s_best_adw), .i_fifo_tbins(fifo_tbins),
        .i_l1a_window(l1a_window), .o_ro_start(s_ro_start), .o_ro_raw_adb(s_ro_raw_adb),
        .o_ro_best_adb(s_ro_best_adb), .o_ro_bxn(s_ro_bxn), .o_ro_l1a_num(s_ro_l1a_num),
        .i_ro_done(ro_done), .o_busy(s_busy), .o_queue_count(s_queue_count),
        .o_queue_full(s_queue_full), .o_l1a_dropped(s_l1a_dropped), .o_drop_cnt(s_drop_cnt),
        .o_ro_error(s_ro_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hard_rst = 1'b0;
        l1a_in   = 1'b0;
        ro_done  = 1'b0;
        tick();
        tick();
        hard_rst = 1'b1;
        tick();
    endtask

    task automatic strobe();
        l1a_in = 1'b1;
        tick();
        l1a_in = 1'b0;
    endtask

    task automatic pulse_done();
        ro_done = 1'b1;
        tick();
        ro_done = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int i;
        i = 0;
        while (ro_start !== 1'b1 && i < 12) begin
            tick();
            i++;
        end
        check({tag, " start"}, 32'(ro_start), 32'd1);
    endtask

    // Waits for the next start, checks the L1A number, then completes the handshake.
    task automatic serve(input string tag, input logic [11:0] exp_num);
        wait_start(tag);
        check({tag, " l1a_num"}, 32'(ro_l1a_num), 32'(exp_num));
        tick();
        pulse_done();
    endtask

    initial begin
        hard_rst   = 1'b0;
        l1a_in     = 1'b0;
        ro_done    = 1'b0;
        l1a_bxn    = '0;
        raw_adw    = '0;
        best_adw   = '0;
        fifo_tbins = '0;
        l1a_window = '0;

        // Reset state
        tick();
        tick();
        check("rst busy", 32'(busy), 0);
        check("rst count", 32'(queue_count), 0);
        check("rst start", 32'(ro_start), 0);
        check("rst drop_cnt", 32'(drop_cnt), 0);
        check("rst error", 32'(ro_error), 0);
        hard_rst = 1'b1;
        tick();

        // Single event latency and contents; ro_done during START ignored
        fifo_tbins = 5'd7;
        l1a_window = 4'd3;
        l1a_bxn    = 12'h123;
        raw_adw    = 8'h10;
        best_adw   = 8'h20;
        strobe();
        check("t1 count", 32'(queue_count), 1);
        check("t1 start N", 32'(ro_start), 0);
        tick();
        check("t1 start N+1", 32'(ro_start), 0);
        check("t1 busy load", 32'(busy), 1);
        tick();
        check("t1 start N+2", 32'(ro_start), 1);
        check("t1 bxn", 32'(ro_bxn), 32'h123);
        check("t1 raw", 32'(ro_raw_adb), 32'h10);
        check("t1 best", 32'(ro_best_adb), 32'h20);
        check("t1 num", 32'(ro_l1a_num), 0);
        ro_done = 1'b1;
        tick();
        ro_done = 1'b0;
        check("t1 start one cycle", 32'(ro_start), 0);
        tick();
        check("t1 done in start ignored", 32'(busy), 1);
        pulse_done();
        check("t1 count in release", 32'(queue_count), 1);
        tick();
        check("t1 count after", 32'(queue_count), 0);
        check("t1 busy after", 32'(busy), 0);
        check("t1 raw held", 32'(ro_raw_adb), 32'h10);

        // Fill to 8, drop the 9th, number gap after the drop
        do_reset();
        l1a_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("t2 full", 32'(queue_full), 1);
        check("t2 count", 32'(queue_count), 8);
        check("t2 no drop yet", 32'(l1a_dropped), 0);
        tick();
        l1a_in = 1'b0;
        check("t2 dropped", 32'(l1a_dropped), 1);
        check("t2 drop_cnt", 32'(drop_cnt), 1);
        tick();
        check("t2 drop pulse", 32'(l1a_dropped), 0);
        check("t2 first num", 32'(ro_l1a_num), 0);
        pulse_done();
        tick();
        check("t2 count post release", 32'(queue_count), 7);
        l1a_bxn = 12'h999;
        strobe();
        check("t2 readmit count", 32'(queue_count), 8);
        check("t2 readmit no drop", 32'(l1a_dropped), 0);
        for (int i = 1; i <= 7; i++) serve("t2 ev", 12'(i));
        wait_start("t2 ev9");
        check("t2 ev9 num", 32'(ro_l1a_num), 9);
        check("t2 ev9 bxn", 32'(ro_bxn), 32'h999);

        // Large events: queue fills before raw memory, reservation released per event
        do_reset();
        fifo_tbins = 5'd31;
        l1a_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        l1a_in = 1'b0;
        check("t3 count", 32'(queue_count), 8);
        check("t3 drop_cnt", 32'(drop_cnt), 0);
        tick();
        pulse_done();
        tick();
        fifo_tbins = 5'd9;
        strobe();
        check("t3 admit 226", 32'(l1a_dropped), 0);
        check("t3 count refill", 32'(queue_count), 8);

        // Drop counter saturation with a full, stalled queue
        l1a_in = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        check("sat 255", 32'(drop_cnt), 255);
        for (int i = 0; i < 5; i++) tick();
        l1a_in = 1'b0;
        check("sat hold", 32'(drop_cnt), 255);

        // L1A coincident with RELEASE at full: rejected, retry admitted
        do_reset();
        fifo_tbins = 5'd1;
        l1a_window = 4'd1;
        l1a_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        l1a_in = 1'b0;
        tick();
        tick();
        ro_done = 1'b1;
        tick();
        ro_done = 1'b0;
        l1a_in  = 1'b1;
        tick();
        check("t4 reject at release", 32'(l1a_dropped), 1);
        check("t4 count 7", 32'(queue_count), 7);
        tick();
        l1a_in = 1'b0;
        check("t4 retry ok", 32'(l1a_dropped), 0);
        check("t4 count 8", 32'(queue_count), 8);
        check("t4 drop_cnt", 32'(drop_cnt), 1);

        // Reset in WAIT_DONE abandons the event and restarts numbering
        do_reset();
        strobe();
        strobe();
        wait_start("t5 pre");
        tick();
        hard_rst = 1'b0;
        ro_done  = 1'b1;
        tick();
        check("t5 busy", 32'(busy), 0);
        check("t5 count", 32'(queue_count), 0);
        check("t5 bxn", 32'(ro_bxn), 0);
        check("t5 raw", 32'(ro_raw_adb), 0);
        check("t5 start", 32'(ro_start), 0);
        hard_rst = 1'b1;
        ro_done  = 1'b0;
        tick();
        check("t5 idle after", 32'(busy), 0);
        l1a_bxn = 12'h0AB;
        strobe();
        wait_start("t5 post");
        check("t5 num restart", 32'(ro_l1a_num), 0);
        check("t5 bxn post", 32'(ro_bxn), 32'h0AB);

        // Raw reservation boundary on a 32-word memory, zero-bin event, release credit
        do_reset();
        fifo_tbins = 5'd16;
        l1a_window = 4'd0;
        strobe();
        strobe();
        check("sm raw 32 admit", 32'(s_l1a_dropped), 0);
        fifo_tbins = 5'd1;
        strobe();
        check("sm raw 33 reject", 32'(s_l1a_dropped), 1);
        fifo_tbins = 5'd0;
        strobe();
        check("sm zero-bin admit", 32'(s_l1a_dropped), 0);
        check("sm count", 32'(s_queue_count), 3);
        tick();
        pulse_done();
        tick();
        fifo_tbins = 5'd16;
        strobe();
        check("sm readmit 16", 32'(s_l1a_dropped), 0);
        fifo_tbins = 5'd1;
        strobe();
        check("sm reject again", 32'(s_l1a_dropped), 1);
        check("sm drop_cnt", 32'(s_drop_cnt), 2);

        // Best reservation boundary
        do_reset();
        fifo_tbins = 5'd0;
        l1a_window = 4'd15;
        strobe();
        strobe();
        l1a_window = 4'd2;
        strobe();
        check("sm best 32 admit", 32'(s_l1a_dropped), 0);
        l1a_window = 4'd1;
        strobe();
        check("sm best 33 reject", 32'(s_l1a_dropped), 1);
        check("sm best count", 32'(s_queue_count), 3);

`ifdef DAQ_TIMEOUT_EN
        // Watchdog releases a stalled event after 1023 WAIT_DONE cycles
        do_reset();
        l1a_window = 4'd1;
        strobe();
        wait_start("wd");
        for (int i = 0; i < 1023; i++) tick();
        check("wd still waiting", 32'(busy), 1);
        check("wd no error yet", 32'(ro_error), 0);
        tick();
        check("wd error", 32'(ro_error), 1);
        tick();
        check("wd freed", 32'(queue_count), 0);
        strobe();
        wait_start("wd next");
        check("wd next num", 32'(ro_l1a_num), 1);
        check("wd error sticky", 32'(ro_error), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
